// File: rtl/hdd_pkg.sv
// Definitions shared by the ProDOS HDD register interface and the SD block bridge:
// transfer FSM states, sector-buffer geometry and ProDOS command/status codes.
package hdd_pkg;

  localparam int BLOCK_BYTES = 512;
  localparam int SEC_ADDR_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_XFER = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_XFER = 3'd4,
    ST_DONE    = 3'd5
  } hdd_state_t;

  // ProDOS block-device command codes and status bytes
  localparam logic [7:0] PRODOS_CMD_STATUS = 8'h00;
  localparam logic [7:0] PRODOS_CMD_READ   = 8'h01;
  localparam logic [7:0] PRODOS_CMD_WRITE  = 8'h02;
  localparam logic [7:0] PRODOS_CMD_FORMAT = 8'h03;
  localparam logic [7:0] PRODOS_STAT_OK    = 8'h00;
  localparam logic [7:0] PRODOS_STAT_IOERR = 8'h27;
  localparam logic [7:0] PRODOS_STAT_NODEV = 8'h28;
  localparam logic [7:0] PRODOS_STAT_WPROT = 8'h2B;

endpackage

// File: rtl/hdd_sd_bridge.sv
// Moves one 512-byte block between the HDD sector buffer and the host SD block
// port, tracks image mount state and holds busy while a transfer is in flight.
module hdd_sd_bridge
  import hdd_pkg::*;
#(
  parameter logic [31:0] LBA_OFFSET = 32'd0,
  parameter int          TIMEOUT_W  = 24
) (
  input  logic                  CLK_14M,
  input  logic                  RESET,
  input  logic                  hdd_read,
  input  logic                  hdd_write,
  input  logic [15:0]           sector,
  output logic                  hdd_mounted,
  output logic                  hdd_protect,
  output logic [SEC_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_di,
  input  logic [7:0]            ram_do,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  error,
  input  logic                  img_mounted,
  input  logic                  img_readonly,
  input  logic [63:0]           img_size,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic [SEC_ADDR_W-1:0] sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  output logic [7:0]            sd_buff_din,
  input  logic                  sd_buff_wr
);

  localparam logic [TIMEOUT_W-1:0] TMAX = '1;
  localparam logic [TIMEOUT_W-1:0] TONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  hdd_state_t           state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] tcnt_inc;

  assign tcnt_inc = tcnt + TONE;

  // ram_do is already a registered RAM output; only expose it while the host reads
  assign sd_buff_din = (state == ST_WR_XFER) ? ram_do : 8'h00;

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      hdd_mounted <= 1'b0;
      hdd_protect <= 1'b0;
      ram_addr    <= '0;
      ram_di      <= 8'h00;
      ram_we      <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      sd_lba      <= 32'h0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
    end else begin
      if (img_mounted) begin
        hdd_mounted <= |img_size;
        hdd_protect <= img_readonly;
      end
      ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (hdd_mounted && (hdd_read || (hdd_write && !hdd_protect))) begin
            sd_lba <= {16'h0, sector} + LBA_OFFSET;
            busy   <= 1'b1;
            error  <= 1'b0;
            if (hdd_read) begin
              sd_rd <= 1'b1;
              state <= ST_RD_REQ;
            end else begin
              sd_wr <= 1'b1;
              state <= ST_WR_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (sd_ack) begin
            // a strobe in the very first ack cycle must not be lost
            sd_rd    <= 1'b0;
            ram_we   <= sd_buff_wr;
            ram_addr <= sd_buff_addr;
            ram_di   <= sd_buff_dout;
            state    <= ST_RD_XFER;
          end else if (tcnt_inc == TMAX) begin
            error <= 1'b1;
            sd_rd <= 1'b0;
            state <= ST_DONE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_WR_REQ: begin
          if (sd_ack) begin
            sd_wr <= 1'b0;
            state <= ST_WR_XFER;
          end else if (tcnt_inc == TMAX) begin
            error <= 1'b1;
            sd_wr <= 1'b0;
            state <= ST_DONE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_RD_XFER: begin
          ram_we   <= sd_buff_wr & sd_ack;
          ram_addr <= sd_buff_addr;
          ram_di   <= sd_buff_dout;
          if (!sd_ack) begin
            state <= ST_DONE;
          end
        end
        ST_WR_XFER: begin
          ram_addr <= sd_buff_addr;
          if (!sd_ack) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
